// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream between the last SDF butterfly stage, the reorder buffer and its consumer.
// The reorder buffer takes the slave side; the upstream/downstream pair takes the master side.
interface fft_bitrev_reorder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_N     = 4
);
   logic                  di_en;
   logic [DATA_WIDTH-1:0] di_re;
   logic [DATA_WIDTH-1:0] di_im;
   logic                  do_en;
   logic [DATA_WIDTH-1:0] do_re;
   logic [DATA_WIDTH-1:0] do_im;
   logic [LOG2_N-1:0]     do_idx;
   logic                  do_last;
   logic                  frame_err;

   modport master (
      output di_en, di_re, di_im,
      input  do_en, do_re, do_im, do_idx, do_last, frame_err
   );

   modport slave (
      input  di_en, di_re, di_im,
      output do_en, do_re, do_im, do_idx, do_last, frame_err
   );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed index order and leave in
// natural order with per-sample index and end-of-frame markers.
module fft_bitrev_reorder #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_N     = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   fft_bitrev_reorder_if.slave     bus
);
   localparam int N      = 1 << LOG2_N;
   localparam int WORD_W = 2 * DATA_WIDTH;

   typedef logic [LOG2_N-1:0] idx_t;
   typedef enum logic {IDLE, READ} rd_state_e;

   function automatic idx_t bitrev(input idx_t a);
      idx_t r;
      r = '0;
      for (int i = 0; i < LOG2_N; i++) r[i] = a[LOG2_N-1-i];
      return r;
   endfunction

   // Two banks of N words, bank select is the address MSB.
   logic [WORD_W-1:0] mem [2*N];

   idx_t                  wr_cnt_q, wr_cnt_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  armed_q, armed_d;
   logic [1:0]            full_q, full_d;
   logic                  frame_err_q, frame_err_d;
   rd_state_e             state_q, state_d;
   idx_t                  rd_cnt_q, rd_cnt_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  do_en_q, do_en_d;
   logic [DATA_WIDTH-1:0] do_re_q, do_re_d;
   logic [DATA_WIDTH-1:0] do_im_q, do_im_d;
   idx_t                  do_idx_q, do_idx_d;
   logic                  do_last_q, do_last_d;

   logic                  wr_en;
   logic                  rd_issue;
   logic                  other_bank;
   logic [1:0]            full_set;
   logic [1:0]            full_clr;
   logic [WORD_W-1:0]     rd_word;

   // After reset a frame may only start once di_en has been seen low, so a frame
   // interrupted by reset is never picked up halfway.
   assign wr_en = bus.di_en & armed_q;

   // NOTE: every combinational output gets a default first, so no path leaves a latch.
   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      armed_d     = armed_q | ~bus.di_en;
      frame_err_d = 1'b0;
      full_set    = '0;
      if (wr_en) begin
         wr_cnt_d = wr_cnt_q + idx_t'(1);
         if (wr_cnt_q == idx_t'(N-1)) begin
            full_set[wr_bank_q] = 1'b1;
            wr_bank_d           = ~wr_bank_q;
         end
      end else if (!bus.di_en && wr_cnt_q != '0) begin
         wr_cnt_d    = '0;
         frame_err_d = 1'b1;
      end
   end

   assign other_bank = ~rd_bank_q;

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      full_clr  = '0;
      rd_issue  = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = READ;
               rd_cnt_d = '0;
            end
         end
         READ: begin
            rd_issue = 1'b1;
            rd_cnt_d = rd_cnt_q + idx_t'(1);
            if (rd_cnt_q == idx_t'(N-1)) begin
               full_clr[rd_bank_q] = 1'b1;
               rd_bank_d           = other_bank;
               // Chain straight into the next bank, even if it fills on this very edge.
               if (!(full_q[other_bank] | full_set[other_bank])) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign full_d  = (full_q | full_set) & ~full_clr;
   assign rd_word = mem[{rd_bank_q, rd_cnt_q}];

   always_comb begin
      do_en_d   = rd_issue;
      do_idx_d  = rd_issue ? rd_cnt_q : '0;
      do_last_d = rd_issue && (rd_cnt_q == idx_t'(N-1));
      do_re_d   = rd_issue ? rd_word[WORD_W-1:DATA_WIDTH] : do_re_q;
      do_im_d   = rd_issue ? rd_word[DATA_WIDTH-1:0]      : do_im_q;
   end

   // NOTE: the sample RAM has no reset; stale contents are never read because full flags gate reads.
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= {bus.di_re, bus.di_im};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         armed_q     <= 1'b0;
         full_q      <= '0;
         frame_err_q <= 1'b0;
         state_q     <= IDLE;
         rd_cnt_q    <= '0;
         rd_bank_q   <= 1'b0;
         do_en_q     <= 1'b0;
         do_re_q     <= '0;
         do_im_q     <= '0;
         do_idx_q    <= '0;
         do_last_q   <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         armed_q     <= armed_d;
         full_q      <= full_d;
         frame_err_q <= frame_err_d;
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_bank_q   <= rd_bank_d;
         do_en_q     <= do_en_d;
         do_re_q     <= do_re_d;
         do_im_q     <= do_im_d;
         do_idx_q    <= do_idx_d;
         do_last_q   <= do_last_d;
      end
   end

   assign bus.do_en     = do_en_q;
   assign bus.do_re     = do_re_q;
   assign bus.do_im     = do_im_q;
   assign bus.do_idx    = do_idx_q;
   assign bus.do_last   = do_last_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the N=8 reorder buffer: per-cycle input/expected-output schedules
// built from the latency rule (input on cycles 0..N-1 -> output on cycles N+1..2N).
module tb_fft_bitrev_reorder;
   localparam int DW = 16;
   localparam int LG = 3;
   localparam int N  = 8;
   localparam int T  = 64;

   logic clk;
   logic rstn;

   fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .LOG2_N(LG)) bus ();

   fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2_N(LG)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   logic          in_en   [T];
   logic [DW-1:0] in_re   [T];
   logic [DW-1:0] in_im   [T];
   logic          ex_en   [T];
   logic [DW-1:0] ex_re   [T];
   logic [DW-1:0] ex_im   [T];
   logic [LG-1:0] ex_idx  [T];
   logic          ex_last [T];
   logic          ex_err  [T];
   logic [DW-1:0] last_re;
   logic [DW-1:0] last_im;

   task automatic check(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
      end
   endtask

   function automatic logic [LG-1:0] bitrev3(input logic [LG-1:0] k);
      return {k[0], k[1], k[2]};
   endfunction

   // mode 0: re = base + 10k, im = -(base + k); mode 1: alternating full-scale extremes
   function automatic logic [DW-1:0] vre(input int mode, input int base, input int k);
      if (mode == 1) return (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
      return 16'(base + k * 10);
   endfunction

   function automatic logic [DW-1:0] vim(input int mode, input int base, input int k);
      if (mode == 1) return (k % 2 == 1) ? 16'h7FFF : 16'h8000;
      return 16'(-base - k);
   endfunction

   task automatic clear_sched();
      for (int t = 0; t < T; t++) begin
         in_en[t] = 1'b0; in_re[t] = '0; in_im[t] = '0;
         ex_en[t] = 1'b0; ex_re[t] = '0; ex_im[t] = '0;
         ex_idx[t] = '0; ex_last[t] = 1'b0; ex_err[t] = 1'b0;
      end
   endtask

   task automatic add_frame(input int start, input int mode, input int base);
      logic [LG-1:0] j3;
      int k;
      for (int j = 0; j < N; j++) begin
         j3 = LG'(j);
         k  = int'(bitrev3(j3));
         in_en[start+j] = 1'b1;
         in_re[start+j] = vre(mode, base, k);
         in_im[start+j] = vim(mode, base, k);
      end
      for (int kk = 0; kk < N; kk++) begin
         ex_en[start+N+1+kk]   = 1'b1;
         ex_re[start+N+1+kk]   = vre(mode, base, kk);
         ex_im[start+N+1+kk]   = vim(mode, base, kk);
         ex_idx[start+N+1+kk]  = LG'(kk);
         ex_last[start+N+1+kk] = (kk == N-1);
      end
   endtask

   task automatic add_junk(input int start, input int len);
      for (int t = start; t < start + len; t++) begin
         in_en[t] = 1'b1;
         in_re[t] = 16'hDEAD;
         in_im[t] = 16'hBEEF;
      end
   endtask

   task automatic run(input int len);
      for (int t = 0; t < len; t++) begin
         bus.di_en = in_en[t];
         bus.di_re = in_re[t];
         bus.di_im = in_im[t];
         @(posedge clk);
         #1;
         if (ex_en[t]) begin
            last_re = ex_re[t];
            last_im = ex_im[t];
         end
         check("do_en",     t, 32'(bus.do_en),     32'(ex_en[t]));
         check("do_idx",    t, 32'(bus.do_idx),    32'(ex_idx[t]));
         check("do_last",   t, 32'(bus.do_last),   32'(ex_last[t]));
         check("do_re",     t, 32'(bus.do_re),     32'(last_re));
         check("do_im",     t, 32'(bus.do_im),     32'(last_im));
         check("frame_err", t, 32'(bus.frame_err), 32'(ex_err[t]));
      end
   endtask

   task automatic idle(input int len);
      bus.di_en = 1'b0;
      for (int t = 0; t < len; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_en"},   0, 32'(bus.do_en),     32'd0);
      check({tag, "_re"},   0, 32'(bus.do_re),     32'd0);
      check({tag, "_im"},   0, 32'(bus.do_im),     32'd0);
      check({tag, "_idx"},  0, 32'(bus.do_idx),    32'd0);
      check({tag, "_last"}, 0, 32'(bus.do_last),   32'd0);
      check({tag, "_err"},  0, 32'(bus.frame_err), 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      last_re = '0;
      last_im = '0;
      rstn = 1'b0;
      bus.di_en = 1'b0;
      bus.di_re = '0;
      bus.di_im = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst");
      rstn = 1'b1;
      idle(2);

      // Single frame: natural-order output on cycles 9..16
      clear_sched();
      add_frame(0, 0, 0);
      run(20);

      // Four back-to-back frames: 32 continuous outputs from cycle 9
      clear_sched();
      for (int f = 0; f < 4; f++) add_frame(8 * f, 0, 100 * (f + 1));
      run(44);

      // Partial frame of 5, one-cycle gap, then a full frame
      clear_sched();
      add_junk(0, 5);
      ex_err[5] = 1'b1;
      add_frame(6, 0, 500);
      run(26);

      // Frame, 20-cycle idle gap, second frame
      clear_sched();
      add_frame(0, 0, 1000);
      add_frame(28, 0, 2000);
      run(48);

      // Full-scale extremes pass bit-exact
      clear_sched();
      add_frame(0, 1, 0);
      run(20);

      // Reset at output index 3 of frame A while frame B is half written
      clear_sched();
      add_frame(0, 0, 3000);
      add_frame(8, 0, 4000);
      run(13);
      rstn = 1'b0;
      #1;
      check_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      last_re = '0;
      last_im = '0;
      clear_sched();
      add_junk(0, 3);
      add_frame(4, 0, 5000);
      run(24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder buffer placed directly downstream of the final radix-2 SDF butterfly/rotate stage.
- That stage emits each N-point frame in bit-reversed index order. This block writes samples at bit-reversed addresses into a ping-pong pair of N-entry banks, then reads them out sequentially.
- It delivers natural-order X[0]..X[N-1] with per-sample index and end-of-frame markers to the downstream consumer.

Parameters:
- DATA_WIDTH, 16, width of each real/imag sample (two's complement, passed through unmodified).
- LOG2_N, 4, log2 of FFT points; N = 2**LOG2_N, bank depth N.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- di_en  input  1  input sample valid; a frame is N consecutive high cycles
- di_re  input  DATA_WIDTH  input real part (bit-reversed order)
- di_im  input  DATA_WIDTH  input imag part
- do_en  output  1  output sample valid
- do_re  output  DATA_WIDTH  output real part (natural order)
- do_im  output  DATA_WIDTH  output imag part
- do_idx  output  LOG2_N  frequency index of the current output sample
- do_last  output  1  high with do_en on index N-1
- frame_err  output  1  one-cycle pulse when a partial frame is aborted

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. Reset clears all counters, bank-select, full flags, read FSM and output registers. do_en, do_re, do_im, do_idx, do_last and frame_err all reset to 0. Bank RAM contents are not reset.
- Reset mid-frame: the partial frame and any pending full bank are discarded. After release, the first complete frame starts at the next di_en rising edge.
- Write side:
  - wr_cnt (LOG2_N bits) and wr_bank (1 bit).
  - Each edge with di_en=1 writes {di_re,di_im} to bank wr_bank at address bitrev(wr_cnt), then increments wr_cnt.
  - At wr_cnt==N-1 with di_en=1: wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
  - di_en=0 with wr_cnt!=0 (gap mid-frame): wr_cnt returns to 0, wr_bank is unchanged (the partial frame is overwritten by the next frame), and frame_err pulses for 1 cycle.
  - di_en=0 with wr_cnt==0: idle, no error.
- Read FSM, states IDLE and READ; registers rd_bank and rd_cnt.
  - IDLE: if full[rd_bank] is set, go to READ with rd_cnt=0 and issue a synchronous read of address 0.
  - READ: issue a read of rd_cnt each cycle.
    - When rd_cnt==N-1: clear full[rd_bank] and toggle rd_bank.
    - If full[other bank] is already set, continue in READ with rd_cnt=0 with no bubble; otherwise go to IDLE.
- Output stage: RAM read data is registered. do_en, do_idx and do_last are aligned to the data: valid one cycle after the read is issued.
- Latency: input samples on cycles 0..N-1 produce outputs valid on cycles N+1..2N, with do_idx=0..N-1 in order.
- Throughput: continuous back-to-back frames give continuous output with no gaps; ping-pong depth is sufficient because read rate equals write rate.
- Simultaneous events:
  - A write-side full set and a read-side full clear on the same edge target different banks and both take effect.
  - A write to bank X and a read from bank Y on the same cycle never share a bank.
- Outputs hold their last do_re/do_im value when do_en=0. do_idx and do_last are 0 when do_en=0.

Test Plan:
- N=8, DATA_WIDTH=16. Reset, then one frame with di_re = bitrev(j)*10 and di_im = -bitrev(j), j=0..7, on cycles 0..7 -> do_en on cycles 9..16, do_re=0,10,...,70, do_im=0,-1,...,-7, do_idx=0..7, do_last only at idx 7.
- Four back-to-back frames (32 continuous di_en cycles) -> 32 continuous do_en cycles starting at cycle 9, each frame in natural order, no bubbles, bank alternation correct.
- di_en high 5 cycles, low 1, then a full 8-sample frame -> frame_err pulses once; only the full frame appears at the output; no output from the partial frame.
- Frame, then an idle gap of 20 cycles, then a second frame -> FSM returns to IDLE between frames; the second output starts exactly N+1 cycles after its first input.
- Assert rstn low at output index 3 of frame A while frame B is half written -> all outputs 0 immediately. After release, the next full frame is output correctly with idx starting at 0.
- Extreme values: input 0x7FFF/0x8000 -> passed bit-exact; no sign or width alteration.
